// File: rtl/twm_pkg.sv
// twm_pkg: shared types and constants for the two-wire initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package twm_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_OP,
        ST_ADDR,
        ST_WDATA,
        ST_TAR,
        ST_RDATA,
        ST_STOP,
        ST_GAP
    } twm_state_e;

    localparam logic OP_WRITE   = 1'b1;
    localparam logic OP_READ    = 1'b0;
    localparam int   ADDR_BITS  = 8;
    localparam int   DATA_BITS  = 16;
    // Address and write data share one shift register: {wdata, addr}.
    localparam int   FRAME_BITS = ADDR_BITS + DATA_BITS;
    localparam int   CNT_W      = 6;

endpackage

// File: rtl/twm_shift.sv
// twm_shift: LSB-first shift register (parallel load / serial out, serial in) plus shared cycle counter.
// Latency: ser_o is the register LSB; rx_nxt_o shows the received word as it will be after this shift.
// Backpressure: none; the owning FSM drives load/shift/clear every cycle.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   load_i/_dat_i   parallel load (wins over shift)
//   shift_i, ser_i  shift right by one, ser_i enters at the MSB
//   ser_o           current LSB (next bit to transmit)
//   rx_nxt_o        top RX_W bits including the bit being shifted in now
//   cnt_clr_i       clear the cycle counter (otherwise it increments)
//   cnt_term_i      terminal count value; cnt_tc_o is high when reached
module twm_shift
    import twm_pkg::*;
#(
    parameter int WIDTH = FRAME_BITS,
    parameter int RX_W  = DATA_BITS
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_dat_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [RX_W-1:0]  rx_nxt_o,
    input  logic             cnt_clr_i,
    input  logic [CNT_W-1:0] cnt_term_i,
    output logic             cnt_tc_o
);

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = load_dat_i;
        end else if (shift_i) begin
            sh_d = {ser_i, sh_q[WIDTH-1:1]};
        end
        cnt_d = cnt_clr_i ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_q  <= '0;
            cnt_q <= '0;
        end else begin
            sh_q  <= sh_d;
            cnt_q <= cnt_d;
        end
    end

    assign ser_o    = sh_q[0];
    // After RX_W shifts the received word sits in the top RX_W bits.
    assign rx_nxt_o = {ser_i, sh_q[WIDTH-1 -: RX_W-1]};
    assign cnt_tc_o = (cnt_q == cnt_term_i);

endmodule

// File: rtl/twm_master.sv
// twm_master: two-wire initiator; serialises host write/read commands onto SDA/SCL, returns read data.
// Latency: write response 27 cycles after acceptance; read response in the slave stop-bit cycle.
// Backpressure: cmd_ready high only in IDLE; commands offered during a frame or gap are not taken.
//
// Ports:
//   clk, reset                   clock, async active-high reset
//   SCL                          high from start bit through last data/stop bit
//   SDA                          open-drain style data line, pulled up on the board
//   cmd_valid/ready/write/addr/wdata   host command
//   rsp_valid/rdata/err          one-cycle completion pulse with read data / timeout flag
// Build option: define TWM_TIMEOUT_EN to abandon a read whose turnaround exceeds TAR_TIMEOUT cycles.
module twm_master
    import twm_pkg::*;
#(
    parameter int IDLE_GAP    = 2,
    parameter int TAR_TIMEOUT = 8
)(
    input  logic                 clk,
    input  logic                 reset,
    output logic                 SCL,
    inout  wire                  SDA,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [ADDR_BITS-1:0] cmd_addr,
    input  logic [DATA_BITS-1:0] cmd_wdata,
    output logic                 rsp_valid,
    output logic [DATA_BITS-1:0] rsp_rdata,
    output logic                 rsp_err
);

    twm_state_e           state_q, state_d;
    logic                 wr_q, wr_d;
    logic                 sda_q, sda_d;
    logic                 sda_oe_q, sda_oe_d;
    logic                 ready_q;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                 sda_in;

    logic                 sh_load, sh_shift, sh_ser;
    logic [DATA_BITS-1:0] sh_rx_nxt;
    logic                 cnt_clr, cnt_tc;
    logic [CNT_W-1:0]     cnt_term;

`ifdef TWM_TIMEOUT_EN
    logic                 rsp_err_q, rsp_err_d;
`endif

    assign SDA    = sda_oe_q ? sda_q : 1'bz;
    assign sda_in = SDA;

    twm_shift #(.WIDTH(FRAME_BITS), .RX_W(DATA_BITS)) u_shift (
        .clk        (clk),
        .rst        (reset),
        .load_i     (sh_load),
        .load_dat_i ({cmd_wdata, cmd_addr}),
        .shift_i    (sh_shift),
        .ser_i      (sda_in),
        .ser_o      (sh_ser),
        .rx_nxt_o   (sh_rx_nxt),
        .cnt_clr_i  (cnt_clr),
        .cnt_term_i (cnt_term),
        .cnt_tc_o   (cnt_tc)
    );

    // The counter restarts from zero in the first cycle of every state.
    assign cnt_clr = (state_d != state_q);

    // sda_d/sda_oe_d are the line values for the *next* cycle, so each state
    // prepares the bit that follows it. The shift register LSB is always the
    // next bit to send: OP sends addr[0], each ADDR/WDATA cycle sends the one after.
    always_comb begin
        state_d     = state_q;
        wr_d        = wr_q;
        sda_d       = 1'b1;
        sda_oe_d    = 1'b1;
        sh_load     = 1'b0;
        sh_shift    = 1'b0;
        cnt_term    = '0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
`ifdef TWM_TIMEOUT_EN
        rsp_err_d   = rsp_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && ready_q) begin
                    state_d = ST_START;
                    wr_d    = cmd_write;
                    sh_load = 1'b1;
                    sda_d   = 1'b0;
                end
            end
            ST_START: begin
                state_d = ST_OP;
                sda_d   = wr_q;
            end
            ST_OP: begin
                state_d  = ST_ADDR;
                sda_d    = sh_ser;
                sh_shift = 1'b1;
            end
            ST_ADDR: begin
                cnt_term = CNT_W'(ADDR_BITS - 1);
                sda_d    = sh_ser;
                sh_shift = 1'b1;
                if (cnt_tc) begin
                    if (wr_q == OP_READ) begin
                        state_d  = ST_TAR;
                        sda_oe_d = 1'b0;
                    end else begin
                        state_d  = ST_WDATA;
                    end
                end
            end
            ST_WDATA: begin
                cnt_term = CNT_W'(DATA_BITS - 1);
                sda_d    = sh_ser;
                sh_shift = 1'b1;
                if (cnt_tc) begin
                    state_d     = ST_GAP;
                    sda_d       = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
`ifdef TWM_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            ST_TAR: begin
                // Counter runs here in every build; only the timeout build acts on it.
                cnt_term = CNT_W'(TAR_TIMEOUT - 1);
                sda_oe_d = 1'b0;
                if (!sda_in) begin
                    state_d = ST_RDATA;
                end
`ifdef TWM_TIMEOUT_EN
                else if (cnt_tc) begin
                    state_d     = ST_GAP;
                    sda_oe_d    = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end
`endif
            end
            ST_RDATA: begin
                cnt_term = CNT_W'(DATA_BITS - 1);
                sda_oe_d = 1'b0;
                sh_shift = 1'b1;
                if (cnt_tc) begin
                    // Respond during the slave stop bit, with the final bit included.
                    state_d     = ST_STOP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = sh_rx_nxt;
`ifdef TWM_TIMEOUT_EN
                    rsp_err_d   = 1'b0;
`endif
                end
            end
            ST_STOP: begin
                state_d = ST_GAP;
            end
            ST_GAP: begin
                cnt_term = CNT_W'(IDLE_GAP - 1);
                if (cnt_tc) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            wr_q        <= OP_READ;
            sda_q       <= 1'b1;
            sda_oe_q    <= 1'b1;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wr_q        <= wr_d;
            sda_q       <= sda_d;
            sda_oe_q    <= sda_oe_d;
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef TWM_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_err_q <= 1'b0;
        end else begin
            rsp_err_q <= rsp_err_d;
        end
    end
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    assign SCL       = (state_q != ST_IDLE) && (state_q != ST_GAP);
    assign cmd_ready = ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_twm_master.sv
// tb_twm_master: directed bench for twm_master with a small slave model on SDA.
// Latency: cycle k counts from 1 = first cycle after command acceptance.
// Backpressure: the bench waits for cmd_ready with a bounded loop.
module tb_twm_master;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    wire         scl;
    wire         SDA;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [7:0]  cmd_addr  = 8'h00;
    logic [15:0] cmd_wdata = 16'h0000;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;

    logic        slv_oe  = 1'b0;
    logic        slv_bit = 1'b1;

    int n_pass  = 0;
    int n_total = 0;

    logic [15:0] slv_mem [0:255];

    logic pat_oe  [0:64];
    logic pat_bit [0:64];
    logic pat_cv  [0:64];
    logic sda_v   [0:64];
    logic scl_v   [0:64];
    logic rdy_v   [0:64];
    logic oe_v    [0:64];

    int          rsp_cnt;
    int          rsp_k_first;
    int          rsp_k_last;
    logic [15:0] rsp_rdata_last;
    logic        rsp_err_last;

    pullup (SDA);
    assign SDA = slv_oe ? slv_bit : 1'bz;

    twm_master #(.IDLE_GAP(2), .TAR_TIMEOUT(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .SCL       (scl),
        .SDA       (SDA),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic clear_pats();
        for (int k = 0; k <= 64; k++) begin
            pat_oe[k]  = 1'b0;
            pat_bit[k] = 1'b1;
            pat_cv[k]  = 1'b0;
        end
    endtask

    // Returns at the accepting rising edge.
    task automatic accept(input logic wr, input logic [7:0] a, input logic [15:0] d);
        int w;
        w = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        while (cmd_ready !== 1'b1 && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL accept: cmd_ready=%b required 1 within 100 cycles", cmd_ready);
        else n_pass++;
        @(posedge clk);
    endtask

    // Steps cycles 1..ncyc after acceptance, driving the slave/host patterns and recording outputs.
    task automatic capture(input int ncyc);
        rsp_cnt = 0; rsp_k_first = 0; rsp_k_last = 0;
        rsp_rdata_last = 16'h0; rsp_err_last = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            #1;
            cmd_valid = pat_cv[k];
            if (k == 1) begin
                cmd_addr  = ~cmd_addr;
                cmd_wdata = ~cmd_wdata;
            end
            slv_oe  = pat_oe[k];
            slv_bit = pat_bit[k];
            @(negedge clk);
            sda_v[k] = SDA;
            scl_v[k] = scl;
            rdy_v[k] = cmd_ready;
            oe_v[k]  = dut.sda_oe_q;
            if (rsp_valid === 1'b1) begin
                rsp_cnt++;
                if (rsp_cnt == 1) rsp_k_first = k;
                rsp_k_last     = k;
                rsp_rdata_last = rsp_rdata;
                rsp_err_last   = rsp_err;
            end
            @(posedge clk);
        end
        slv_oe = 1'b0;
    endtask

    // Checks a whole write frame recorded by capture and commits it to the slave memory.
    task automatic check_write_frame(input string nm, input logic [7:0] a, input logic [15:0] d);
        logic [63:0] got, exp;
        logic [7:0]  da;
        logic [15:0] dd;
        got = '0; exp = '0;
        for (int k = 1; k <= 28; k++) begin
            got[k] = sda_v[k];
            if (k == 1)       exp[k] = 1'b0;
            else if (k == 2)  exp[k] = 1'b1;
            else if (k <= 10) exp[k] = a[k-3];
            else if (k <= 26) exp[k] = d[k-11];
            else              exp[k] = 1'b1;
        end
        n_total++;
        if (got !== exp) $display("FAIL %s_sda: got %h required %h", nm, got, exp);
        else n_pass++;

        n_total++;
        if (rsp_cnt !== 1 || rsp_k_first !== 27 || rsp_err_last !== 1'b0 || rsp_rdata_last !== 16'h0)
            $display("FAIL %s_rsp: cnt=%0d at=%0d err=%b rdata=%h required 1/27/0/0000",
                     nm, rsp_cnt, rsp_k_first, rsp_err_last, rsp_rdata_last);
        else n_pass++;

        if (sda_v[1] == 1'b0 && sda_v[2] == 1'b1) begin
            for (int i = 0; i < 8; i++)  da[i] = sda_v[3+i];
            for (int i = 0; i < 16; i++) dd[i] = sda_v[11+i];
            slv_mem[da] = dd;
        end
        n_total++;
        if (slv_mem[a] !== d) $display("FAIL %s_slave_reg: got %h required %h", nm, slv_mem[a], d);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #3;
        n_total++;
        if ({SDA, scl, cmd_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0})
            $display("FAIL reset_outputs: sda=%b scl=%b rdy=%b rv=%b err=%b rdata=%h required 1 0 0 0 0 0000",
                     SDA, scl, cmd_ready, rsp_valid, rsp_err, rsp_rdata);
        else n_pass++;
        n_total++;
        if (dut.sda_oe_q !== 1'b1) $display("FAIL reset_oe: got %b required 1", dut.sda_oe_q);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_total++;
        if (cmd_ready !== 1'b1) $display("FAIL reset_ready_after: got %b required 1", cmd_ready);
        else n_pass++;
    endtask

    task automatic test_write();
        logic [63:0] got, exp;
        clear_pats();
        accept(1'b1, 8'h3C, 16'hA5F0);
        capture(30);
        check_write_frame("write", 8'h3C, 16'hA5F0);
        got = '0; exp = '0;
        for (int k = 1; k <= 29; k++) begin
            got[k]    = scl_v[k];
            exp[k]    = (k <= 26);
            got[k+32] = rdy_v[k];
            exp[k+32] = (k == 29);
        end
        n_total++;
        if (got !== exp) $display("FAIL write_scl_ready: got %h required %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_read();
        logic [15:0] d;
        logic [63:0] got, exp;
        d = 16'h1234;
        clear_pats();
        for (int k = 11; k <= 29; k++) pat_oe[k] = 1'b1;
        pat_bit[11] = 1'b1;
        pat_bit[12] = 1'b1;
        pat_bit[13] = 1'b0;
        for (int i = 0; i < 16; i++) pat_bit[14+i] = d[i];
        accept(1'b0, 8'h3C, 16'h0);
        capture(34);
        n_total++;
        if (rsp_cnt !== 1 || rsp_k_first !== 30 || rsp_rdata_last !== 16'h1234 || rsp_err_last !== 1'b0)
            $display("FAIL read_rsp: cnt=%0d at=%0d rdata=%h err=%b required 1/30/1234/0",
                     rsp_cnt, rsp_k_first, rsp_rdata_last, rsp_err_last);
        else n_pass++;
        got = '0; exp = '0;
        for (int k = 1; k <= 32; k++) begin
            got[k] = oe_v[k];
            exp[k] = !(k >= 11 && k <= 30);
        end
        n_total++;
        if (got !== exp) $display("FAIL read_release: oe got %h required %h", got, exp);
        else n_pass++;
        got = '0; exp = '0;
        for (int k = 1; k <= 33; k++) begin
            got[k] = scl_v[k];
            exp[k] = (k <= 30);
            got[k+34] = rdy_v[k];
            exp[k+34] = (k == 33);
        end
        got[0] = sda_v[31] & sda_v[32];
        exp[0] = 1'b1;
        n_total++;
        if (got !== exp) $display("FAIL read_scl_ready_gap: got %h required %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_busy_ignore();
        logic [15:0] d;
        logic [63:0] got, exp;
        d = 16'hBEEF;
        clear_pats();
        for (int k = 11; k <= 27; k++) pat_oe[k] = 1'b1;
        pat_bit[11] = 1'b0;
        for (int i = 0; i < 16; i++) pat_bit[12+i] = d[i];
        pat_cv[5] = 1'b1;
        pat_cv[6] = 1'b1;
        accept(1'b0, 8'h10, 16'h0);
        capture(32);
        n_total++;
        if (rsp_cnt !== 1 || rsp_k_first !== 28 || rsp_rdata_last !== 16'hBEEF)
            $display("FAIL busy_rsp: cnt=%0d at=%0d rdata=%h required 1/28/beef",
                     rsp_cnt, rsp_k_first, rsp_rdata_last);
        else n_pass++;
        got = '0; exp = '0;
        for (int k = 1; k <= 32; k++) begin
            got[k] = rdy_v[k];
            exp[k] = (k >= 31);
        end
        n_total++;
        if (got !== exp) $display("FAIL busy_ready: got %h required %h", got, exp);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] got, exp;
        clear_pats();
        for (int k = 1; k <= 29; k++) pat_cv[k] = 1'b1;
        accept(1'b1, 8'h21, 16'h0F0F);
        capture(60);
        got = '0; exp = '0;
        for (int k = 1; k <= 60; k++) begin
            got[k] = rdy_v[k];
            exp[k] = (k == 29) || (k >= 58);
        end
        n_total++;
        if (got !== exp) $display("FAIL b2b_ready: got %h required %h", got, exp);
        else n_pass++;
        n_total++;
        if ({sda_v[27], sda_v[28], sda_v[29], sda_v[30]} !== 4'b1110)
            $display("FAIL b2b_gap: sda k27..30 got %b%b%b%b required 1110",
                     sda_v[27], sda_v[28], sda_v[29], sda_v[30]);
        else n_pass++;
        n_total++;
        if (rsp_cnt !== 2 || rsp_k_first !== 27 || rsp_k_last !== 56 || rsp_rdata_last !== 16'h0)
            $display("FAIL b2b_rsp: cnt=%0d first=%0d last=%0d rdata=%h required 2/27/56/0000",
                     rsp_cnt, rsp_k_first, rsp_k_last, rsp_rdata_last);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int seen;
        seen = 0;
        clear_pats();
        accept(1'b1, 8'h77, 16'hFF00);
        #1 cmd_valid = 1'b0;
        repeat (14) @(posedge clk);
        #2;
        n_total++;
        if ({SDA, scl} !== 2'b01) $display("FAIL rstmid_pre: sda=%b scl=%b required 0 1", SDA, scl);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if ({SDA, scl, cmd_ready} !== 3'b100)
            $display("FAIL rstmid_async: sda=%b scl=%b rdy=%b required 1 0 0", SDA, scl, cmd_ready);
        else n_pass++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) seen++;
            if (i == 2) reset = 1'b0;
        end
        n_total++;
        if (seen !== 0) $display("FAIL rstmid_no_rsp: rsp_valid seen %0d times required 0", seen);
        else n_pass++;
        clear_pats();
        accept(1'b1, 8'h5A, 16'h1357);
        capture(30);
        check_write_frame("rstmid_fresh", 8'h5A, 16'h1357);
    endtask

`ifdef TWM_TIMEOUT_EN
    task automatic test_timeout();
        logic [63:0] got, exp;
        clear_pats();
        accept(1'b0, 8'h3C, 16'h0);
        capture(24);
        n_total++;
        if (rsp_cnt !== 1 || rsp_k_first !== 19 || rsp_err_last !== 1'b1 || rsp_rdata_last !== 16'h0)
            $display("FAIL timeout_rsp: cnt=%0d at=%0d err=%b rdata=%h required 1/19/1/0000",
                     rsp_cnt, rsp_k_first, rsp_err_last, rsp_rdata_last);
        else n_pass++;
        got = '0; exp = '0;
        for (int k = 1; k <= 21; k++) begin
            got[k] = oe_v[k];
            exp[k] = !(k >= 11 && k <= 18);
        end
        n_total++;
        if (got !== exp) $display("FAIL timeout_release: oe got %h required %h", got, exp);
        else n_pass++;
        clear_pats();
        accept(1'b1, 8'h3C, 16'h4242);
        capture(30);
        check_write_frame("timeout_next", 8'h3C, 16'h4242);
    endtask
`endif

    initial begin
        for (int i = 0; i < 256; i++) slv_mem[i] = 16'h0;
        clear_pats();
        test_reset();
        test_write();
        test_read();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
`ifdef TWM_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/twm_master.md
Name: twm_master

Overview:
- Two-Wire Protocol (TWM) initiator: drives SDA/SCL toward the two-wire slave register block.
- Turns host commands (write/read, 8-bit address, 16-bit data) into serial frames and returns read data to the host.
- Lives in the bench/SoC host side, on the opposite end of the same SDA wire as the slave's register file.

Parameters:
- IDLE_GAP, 2, minimum cycles SDA held high after a frame before the next start bit.
- TAR_TIMEOUT, 8, maximum cycles waited in read turnaround for the slave's start-of-data 0 (only with TWM_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all sampling and driving on rising edge.
- reset  in  1  asynchronous, active-high reset.
- SCL  out  1  frame-active strobe; high in every cycle from start bit through the last data/stop bit, low otherwise.
- SDA  inout  1  serial data; open when released, board pull-up; Z sampled as 1.
- cmd_valid  in  1  host command request.
- cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid && cmd_ready.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  8  register address.
- cmd_wdata  in  16  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  16  read data, valid with rsp_valid (0 for writes).
- rsp_err  out  1  read timeout flag, valid with rsp_valid.

Behaviour:
- Reset (async, any state): state=IDLE; SDA driven 1 (oe=1); SCL=0; cmd_ready=0 while reset is high, 1 the cycle after release; rsp_valid=0, rsp_rdata=0, rsp_err=0. Reset mid-frame abandons the frame with no response.
- Inputs are captured on acceptance, so the host may change them afterwards. Bit order is LSB first throughout. SDA outputs are registered.
- States: IDLE, START, OP, ADDR, WDATA, TAR, RDATA, STOP, GAP.
- Write, with acceptance at cycle t:
  - SDA=0 (start) at t+1; opcode 1 at t+2; addr[0..7] at t+3..t+10; wdata[0..15] at t+11..t+26.
  - GAP at t+27..t+26+IDLE_GAP with SDA=1; rsp_valid pulses at t+27 (err=0).
  - cmd_ready returns the cycle after the gap ends.
- Read:
  - START, opcode 0, ADDR as above.
  - From t+11, SDA is released (TAR) and sampled each cycle; the first 0 sampled marks start-of-data.
  - The next 16 cycles (RDATA) shift into rsp_rdata LSB first.
  - STOP: one more released cycle (slave stop bit, not checked).
  - rsp_valid pulses in the STOP cycle, then GAP with SDA driven 1 for IDLE_GAP cycles.
  - Any 1s before the 0 in TAR are ignored.
- SCL=1 from START through the last WDATA bit (write) or through STOP (read); 0 in IDLE/GAP.
- cmd_valid during a frame: ignored (cmd_ready=0); no queueing.
- A 6-bit cycle counter is shared by ADDR, WDATA, RDATA and GAP, and is cleared on every state change.

Optional Feature:
- Macro TWM_TIMEOUT_EN.
- Defined: TAR counts cycles. If no 0 is seen within TAR_TIMEOUT cycles, go to GAP (SDA driven 1) and pulse rsp_valid with rsp_err=1, rsp_rdata=16'h0000.
- Undefined: TAR waits indefinitely; rsp_err is tied to 0; the TAR_TIMEOUT parameter is unused.

Decomposition:
- Package twm_pkg: state enum; OP_WRITE=1, OP_READ=0; ADDR_BITS=8, DATA_BITS=16.
- One sub-module, twm_shift: loadable LSB-first shift register (parallel load/serial out for TX, serial in/parallel out for RX) plus a bit counter with a terminal-count flag.
- The FSM, SDA tristate control and response logic stay in twm_master.

Test Plan:
- Write addr=8'h3C, data=16'hA5F0 -> SDA sequence 0,1, bits of 3C LSB-first, bits of A5F0 LSB-first, then 1; rsp_valid at t+27, err=0; slave register 3C reads A5F0 afterwards.
- Read addr=8'h3C with slave model returning 16'h1234 after a turnaround of 1,1,0 -> rsp_rdata=16'h1234, err=0; SDA released (Z) from t+11 through STOP.
- Back-to-back commands with cmd_valid held high -> second start bit no earlier than IDLE_GAP cycles of SDA=1 after the first frame; cmd_ready low throughout each frame.
- With TWM_TIMEOUT_EN, a slave that never drives 0 -> rsp_valid after 8 TAR cycles, err=1, rdata=0; next command accepted normally.
- Reset asserted mid-WDATA -> SDA=1 and SCL=0 immediately (async), no rsp_valid; a fresh write after release completes correctly.
- cmd_valid pulsed during an active read -> ignored; exactly one rsp_valid, for the original read.
